// File: rtl/plu_pkg.sv
// Shared types and sizing helpers for the programmable logic unit.
package plu_pkg;

  localparam int unsigned HIT_W    = 16;
  localparam int unsigned DEF_N_IN = 3;

  function automatic int unsigned tt_w(input int unsigned n);
    return 1 << n;
  endfunction

  // Bit counter carries one spare bit above the table index width.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(tt_w(n)) + 1;
  endfunction

  localparam int unsigned CNT_W = cnt_w(DEF_N_IN);

  typedef enum logic {
    PLU_IDLE,
    PLU_LOAD
  } plu_state_e;

endpackage

// File: rtl/plu_tt_loader.sv
// Serial truth-table loader: collects TT_W bits into a shadow register and
// emits a one-cycle commit pulse with the completed table.
module plu_tt_loader
  import plu_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic                    cfg_valid,
  input  logic                    cfg_bit,
  output logic                    cfg_busy,
  output logic                    commit,
  output logic [tt_w(N_IN)-1:0]   commit_tt
);

  localparam int unsigned TT_W  = tt_w(N_IN);
  localparam int unsigned IDX_W = $clog2(TT_W);
  localparam int unsigned BC_W  = cnt_w(N_IN);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(TT_W - 1);

  plu_state_e      state, state_nxt;
  logic [TT_W-1:0] shadow, shadow_nxt;
  logic [BC_W-1:0] bit_cnt, bit_cnt_nxt;
  logic            commit_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PLU_IDLE;
      shadow  <= '0;
      bit_cnt <= '0;
      commit  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shadow  <= shadow_nxt;
      bit_cnt <= bit_cnt_nxt;
      commit  <= commit_nxt;
    end
  end

  // cfg_start wins over a same-cycle final bit, so a restart never commits.
  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    bit_cnt_nxt = bit_cnt;
    commit_nxt  = 1'b0;
    if (cfg_start) begin
      state_nxt   = PLU_LOAD;
      shadow_nxt  = '0;
      bit_cnt_nxt = '0;
    end else if (state == PLU_LOAD && cfg_valid) begin
      shadow_nxt[bit_cnt[IDX_W-1:0]] = cfg_bit;
      if (bit_cnt == LAST_IDX) begin
        state_nxt  = PLU_IDLE;
        commit_nxt = 1'b1;
      end else begin
        bit_cnt_nxt = bit_cnt + 1'b1;
      end
    end
  end

  // Shadow is complete and stable during the commit cycle.
  assign commit_tt = shadow;
  assign cfg_busy  = (state == PLU_LOAD) | commit;

endmodule

// File: rtl/prog_logic_unit.sv
// Programmable N-input boolean evaluator, LANES lanes per beat, one shared table.
// Optional per-lane hit counters enabled by defining PLU_HITCNT_EN.
module prog_logic_unit
  import plu_pkg::*;
#(
  parameter int unsigned                N_IN     = 3,
  parameter int unsigned                LANES    = 4,
  parameter logic [tt_w(N_IN)-1:0]      RESET_TT = 8'hF8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic                    cfg_valid,
  input  logic                    cfg_bit,
  output logic                    cfg_busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*N_IN-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_data
`ifdef PLU_HITCNT_EN
  , output logic [LANES*HIT_W-1:0] hit_cnt
`endif
);

  localparam int unsigned TT_W = tt_w(N_IN);

  logic [TT_W-1:0]  active_tt;
  logic [TT_W-1:0]  commit_tt;
  logic             commit;
  logic             accept;
  logic [LANES-1:0] lane_res;

  plu_tt_loader #(
    .N_IN (N_IN)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .commit    (commit),
    .commit_tt (commit_tt)
  );

  always_comb begin
    lane_res = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_res[k] = active_tt[in_data[k*N_IN +: N_IN]];
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A beat accepted in the commit cycle still sees the old table.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_tt <= RESET_TT;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (commit) begin
        active_tt <= commit_tt;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= lane_res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PLU_HITCNT_EN
  always_ff @(posedge clk) begin
    if (rst || cfg_start) begin
      hit_cnt <= '0;
    end else if (out_valid && out_ready) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (out_data[k] && hit_cnt[k*HIT_W +: HIT_W] != '1) begin
          hit_cnt[k*HIT_W +: HIT_W] <= hit_cnt[k*HIT_W +: HIT_W] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_prog_logic_unit.sv
// Self-checking bench for prog_logic_unit with a behavioural reference model.
module tb_prog_logic_unit;

  localparam int unsigned N_IN  = 3;
  localparam int unsigned LANES = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cfg_start = 1'b0;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_bit = 1'b0;
  logic                  cfg_busy;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES*N_IN-1:0] in_data = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [LANES-1:0]      out_data;
`ifdef PLU_HITCNT_EN
  logic [LANES*16-1:0]   hit_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prog_logic_unit #(
    .N_IN     (N_IN),
    .LANES    (LANES),
    .RESET_TT (8'hF8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PLU_HITCNT_EN
    , .hit_cnt (hit_cnt)
`endif
  );

  // Reference model state
  logic [7:0] m_tt = 8'hF8;
  logic       m_load = 1'b0;
  int         m_n = 0;
  logic [7:0] m_sh = '0;
  logic       m_pend = 1'b0;
  logic [7:0] m_pend_tt = '0;
  logic       m_ov = 1'b0;
  logic [3:0] m_od = '0;
  int         m_hit [LANES];

  function automatic logic [3:0] eval_tt(input logic [7:0] tt, input logic [11:0] d);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = tt[(d >> (3*k)) & 12'd7];
    return r;
  endfunction

  function automatic logic [3:0] xor_ref(input logic [11:0] d);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = ^d[k*3 +: 3];
    return r;
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_tt = 8'hF8; m_load = 1'b0; m_n = 0; m_sh = '0; m_pend = 1'b0;
      m_ov = 1'b0; m_od = '0;
      for (int k = 0; k < LANES; k++) m_hit[k] = 0;
    end else begin
      if (cfg_start) begin
        for (int k = 0; k < LANES; k++) m_hit[k] = 0;
      end else if (m_ov && out_ready) begin
        for (int k = 0; k < LANES; k++)
          if (m_od[k] && m_hit[k] < 65535) m_hit[k]++;
      end
      if (in_valid && (!m_ov || out_ready)) begin
        m_od = eval_tt(m_tt, in_data);
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (m_pend) begin
        m_tt = m_pend_tt;
        m_pend = 1'b0;
      end
      if (cfg_start) begin
        m_load = 1'b1; m_n = 0; m_sh = '0;
      end else if (m_load && cfg_valid) begin
        m_sh[m_n] = cfg_bit;
        m_n++;
        if (m_n == 8) begin
          m_load = 1'b0; m_pend = 1'b1; m_pend_tt = m_sh;
        end
      end
    end
  endfunction

  // Advance one clock: model sees the inputs the DUT samples, then inputs may change.
  task automatic next();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start_load();
    next();
    cfg_start = 1'b1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] tt, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      next();
      cfg_start = 1'b0;
      cfg_valid = 1'b1;
      cfg_bit   = tt[3'(i)];
    end
    next();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next();
    next();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL reset_out_data: got %b expected 0000", out_data); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy: got %b expected 0", cfg_busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    next();
    rst = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = {3'b010, 3'b100, 3'b011, 3'b000};
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got out_valid=%b expected 0", out_valid); end
    next();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL default_tt_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 4'b0110) begin errors++; $display("FAIL default_tt_data: got %b expected 0110", out_data); end
  endtask

  task automatic test_load_xor();
    int busy_cycles = 0;
    logic [7:0] tt = 8'h96;
    logic [3:0] exp_prev = '0;
    logic [11:0] d;
    next();
    cfg_start = 1'b1;
    @(negedge clk);
    if (cfg_busy) busy_cycles++;
    for (int i = 0; i < 8; i++) begin
      next();
      cfg_start = 1'b0;
      cfg_valid = 1'b1;
      cfg_bit   = tt[i];
      @(negedge clk);
      if (cfg_busy) busy_cycles++;
      checks++; if (cfg_busy !== (m_load || m_pend)) begin errors++; $display("FAIL load_busy_model: got %b expected %b", cfg_busy, m_load || m_pend); end
    end
    for (int i = 0; i < 4; i++) begin
      next();
      cfg_valid = 1'b0;
      @(negedge clk);
      if (cfg_busy) busy_cycles++;
    end
    checks++; if (busy_cycles != 9) begin errors++; $display("FAIL busy_cycles: got %0d expected 9", busy_cycles); end
    for (int p = 0; p < 8; p++) begin
      next();
      d = '0;
      for (int k = 0; k < 4; k++) d[k*3 +: 3] = 3'((p + k) % 8);
      in_valid = 1'b1;
      out_ready = 1'b1;
      in_data = d;
      @(negedge clk);
      if (p > 0) begin
        checks++; if (out_data !== exp_prev) begin errors++; $display("FAIL xor_pattern: got %b expected %b", out_data, exp_prev); end
      end
      exp_prev = xor_ref(d);
    end
    next();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_data !== exp_prev) begin errors++; $display("FAIL xor_pattern_last: got %b expected %b", out_data, exp_prev); end
  endtask

  task automatic test_backpressure();
    logic [11:0] d0, d1;
    logic [3:0] q[$];
    int sent = 0;
    int got = 0;
    next();
    d0 = 12'($urandom);
    in_valid = 1'b1;
    in_data = d0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b expected 1", in_ready); end
    next();
    d1 = 12'($urandom);
    in_data = d1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== xor_ref(d0)) begin errors++; $display("FAIL bp_hold: got v=%b d=%b expected v=1 d=%b", out_valid, out_data, xor_ref(d0)); end
      next();
    end
    q.push_back(xor_ref(d0));
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stream: got ready=%b valid=%b expected 1 1", in_ready, out_valid); end
      if (out_valid && out_ready && q.size() > 0) begin
        got++;
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL bp_stream_data: got %b expected %b", out_data, q[0]); end
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(xor_ref(in_data));
        sent++;
      end
      next();
      in_data = 12'($urandom);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && q.size() > 0) begin
        got++;
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL bp_drain_data: got %b expected %b", out_data, q[0]); end
        void'(q.pop_front());
      end
      next();
    end
    checks++; if (got != sent + 1) begin errors++; $display("FAIL bp_count: got %0d delivered expected %0d", got, sent + 1); end
  endtask

  task automatic test_commit_cycle();
    logic [11:0] d = {3'd5, 3'd4, 3'd3, 3'd2};
    start_load();
    send_bits(8'h3C, 8);
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = d;
    @(negedge clk);
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL commit_busy: got %b expected 1", cfg_busy); end
    next();
    @(negedge clk);
    checks++; if (out_data !== 4'b0101) begin errors++; $display("FAIL commit_old_table: got %b expected 0101", out_data); end
    next();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_data !== 4'b1111) begin errors++; $display("FAIL commit_new_table: got %b expected 1111", out_data); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL commit_busy_drop: got %b expected 0", cfg_busy); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      next();
      cfg_start = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 2) != 0);
      cfg_bit   = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 12'($urandom);
      @(negedge clk);
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid: got %b expected %b", out_valid, m_ov); end
      if (m_ov) begin
        checks++; if (out_data !== m_od) begin errors++; $display("FAIL rnd_out_data: got %b expected %b", out_data, m_od); end
      end
      checks++; if (in_ready !== (!m_ov || out_ready)) begin errors++; $display("FAIL rnd_in_ready: got %b expected %b", in_ready, !m_ov || out_ready); end
      checks++; if (cfg_busy !== (m_load || m_pend)) begin errors++; $display("FAIL rnd_cfg_busy: got %b expected %b", cfg_busy, m_load || m_pend); end
    end
    next();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_restart_reset();
    start_load();
    send_bits(8'hF0, 4);
    start_load();
    send_bits(8'h01, 8);
    next();
    @(negedge clk);
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL restart_busy: got %b expected 0", cfg_busy); end
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = {3'b100, 3'b010, 3'b001, 3'b000};
    next();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_data !== 4'b0001) begin errors++; $display("FAIL restart_table: got %b expected 0001", out_data); end
    start_load();
    send_bits(8'hAA, 5);
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_data = 12'($urandom);
    next();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || cfg_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got v=%b busy=%b expected 1 1", out_valid, cfg_busy); end
    next();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || cfg_busy !== 1'b0 || out_data !== 4'b0000) begin errors++; $display("FAIL abort_reset: got v=%b busy=%b d=%b expected 0 0 0000", out_valid, cfg_busy, out_data); end
    next();
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = {3'b010, 3'b100, 3'b011, 3'b000};
    next();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_data !== 4'b0110) begin errors++; $display("FAIL reset_table_restored: got %b expected 0110", out_data); end
    checks++; if (out_data !== m_od) begin errors++; $display("FAIL reset_model: got %b expected %b", out_data, m_od); end
  endtask

`ifdef PLU_HITCNT_EN
  task automatic test_hitcnt();
    next();
    cfg_start = 1'b1;
    next();
    cfg_start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 12'hFFF;
    for (int c = 0; c < 70000; c++) next();
    in_valid = 1'b0;
    next();
    next();
    @(negedge clk);
    for (int k = 0; k < LANES; k++) begin
      checks++; if (hit_cnt[k*16 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL hit_saturate lane %0d: got %h expected ffff", k, hit_cnt[k*16 +: 16]); end
      checks++; if (hit_cnt[k*16 +: 16] !== 16'(m_hit[k])) begin errors++; $display("FAIL hit_model lane %0d: got %h expected %h", k, hit_cnt[k*16 +: 16], 16'(m_hit[k])); end
    end
    next();
    cfg_start = 1'b1;
    next();
    cfg_start = 1'b0;
    @(negedge clk);
    checks++; if (hit_cnt !== '0) begin errors++; $display("FAIL hit_clear: got %h expected 0", hit_cnt); end
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < LANES; k++) m_hit[k] = 0;
    test_reset();
    test_load_xor();
    test_backpressure();
    test_commit_cycle();
    test_random();
    test_restart_reset();
`ifdef PLU_HITCNT_EN
    test_hitcnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
